// File: rtl/uart_div_pkg.sv
// uart_div_pkg: shared constants, state enums, 7-segment glyphs and double-dabble step for uart_div_display
package uart_div_pkg;
  localparam logic [7:0] HEADER_BYTE = 8'h73;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 9600;
  typedef enum logic [2:0] {WAIT_HA, GET_A, WAIT_HB, GET_B, DIV, BCD, DONE} ctl_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_E, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
  function automatic logic [6:0] glyph(input logic [3:0] n);
    return SEG_TABLE[n];
  endfunction
  function automatic logic [11:0] dd_step(input logic [11:0] d, input logic b);
    logic [11:0] a;
    for (int i = 0; i < 3; i++) a[4*i +: 4] = d[4*i +: 4] >= 4'd5 ? d[4*i +: 4] + 4'd3 : d[4*i +: 4];
    return {a[10:0], b};
  endfunction
endpackage

// File: rtl/uart_div_display_if.sv
// uart_div_display_if: rx pin, received byte, tx result, BCD result and LED scan outputs; slave = block view, master = board/bench view
interface uart_div_display_if;
  logic rx;
  logic [7:0] rx_data;
  logic rx_ready;
  logic [7:0] tx_data;
  logic tx_ready;
  logic [23:0] y_to_led;
  logic [6:0] led_out;
  logic [5:0] dig;
  modport master(output rx, input rx_data, rx_ready, tx_data, tx_ready, y_to_led, led_out, dig);
  modport slave(input rx, output rx_data, rx_ready, tx_data, tx_ready, y_to_led, led_out, dig);
endinterface

// File: rtl/uart_div_display_rx_uart.sv
// rx_uart: 8N1 receiver (clk, rst, rx in; data byte out with one-cycle ready pulse), start bit rechecked at half bit, bad stop drops byte
import uart_div_pkg::*;
module rx_uart #(
  parameter int BIT_CYCLES = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic [7:0] data,
  output logic ready
);
  rx_state_t st;
  logic [15:0] cnt;
  logic [2:0] n;
  logic [7:0] sh;
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s3, s2, s1} <= 3'b111;
      st <= RX_IDLE;
      cnt <= '0;
      n <= '0;
      sh <= '0;
      data <= '0;
      ready <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, rx};
      ready <= 1'b0;
      cnt <= cnt + 16'd1;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (s3 && !s2) st <= RX_START;
        end
        RX_START: if (cnt == 16'(BIT_CYCLES / 2 - 1)) begin
          cnt <= '0;
          n <= '0;
          st <= s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == 16'(BIT_CYCLES - 1)) begin
          cnt <= '0;
          sh <= {s2, sh[7:1]};
          n <= n + 3'd1;
          if (n == 3'd7) st <= RX_STOP;
        end
        default: if (cnt == 16'(BIT_CYCLES - 1)) begin
          st <= RX_IDLE;
          if (s2) begin
            data <= sh;
            ready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_div_display.sv
// uart_div_display: header-tagged A/B over UART -> Q=A/B, R=A%B as BCD on 6-digit scanned LEDs and tx byte (clk, rst, bus: rx in; rx_data/rx_ready, tx_data/tx_ready, y_to_led, led_out, dig out); LED_ZERO_BLANK_EN blanks leading zeros
import uart_div_pkg::*;
module uart_div_display #(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int SCAN_CYCLES = 50_000
) (
  input logic clk,
  input logic rst,
  uart_div_display_if.slave bus
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  ctl_state_t st, nxt;
  logic [7:0] rxd, a, b, q, r;
  logic rdy, ge, blank;
  logic [2:0] cnt, idx;
  logic [8:0] t;
  logic [11:0] bq, br;
  logic [31:0] sc;
  logic [3:0] nib;
  rx_uart #(.BIT_CYCLES(BIT_CYCLES)) u_rx (.clk, .rst, .rx(bus.rx), .data(rxd), .ready(rdy));
  assign bus.rx_data = rxd;
  assign bus.rx_ready = rdy;
  always_ff @(posedge clk) st <= rst ? WAIT_HA : nxt;
  always_comb begin
    nxt = st;
    case (st)
      WAIT_HA: if (rdy && rxd == HEADER_BYTE) nxt = GET_A;
      GET_A:   if (rdy) nxt = WAIT_HB;
      WAIT_HB: if (rdy && rxd == HEADER_BYTE) nxt = GET_B;
      GET_B:   if (rdy) nxt = rxd == 8'd0 ? DONE : DIV;
      DIV:     if (cnt == 3'd7) nxt = BCD;
      BCD:     if (cnt == 3'd7) nxt = DONE;
      default: nxt = WAIT_HA;
    endcase
  end
  assign t = {r, q[7]};
  assign ge = t >= {1'b0, b};
  always_ff @(posedge clk) begin
    if (rst) begin
      {a, b, q, r, bq, br, cnt} <= '0;
      bus.tx_data <= '0;
      bus.tx_ready <= 1'b0;
      bus.y_to_led <= '0;
    end else begin
      bus.tx_ready <= st == DONE;
      cnt <= (st == DIV || st == BCD) ? cnt + 3'd1 : 3'd0;
      if (st == GET_A && rdy) a <= rxd;
      if (st == GET_B && rdy) begin
        b <= rxd;
        q <= a;
        {r, bq, br} <= '0;
      end
      if (st == DIV) begin
        q <= {q[6:0], ge};
        r <= ge ? 8'(t - {1'b0, b}) : t[7:0];
      end
      // q and r stay intact; bits are fed MSB first by index so Q survives for tx_data
      if (st == BCD) begin
        bq <= dd_step(bq, q[~cnt]);
        br <= dd_step(br, r[~cnt]);
      end
      if (st == DONE) begin
        bus.y_to_led <= b == 8'd0 ? 24'hEEEEEE : {bq, br};
        bus.tx_data <= b == 8'd0 ? 8'hFF : q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
      idx <= '0;
    end else if (sc == 32'(SCAN_CYCLES - 1)) begin
      sc <= '0;
      idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
    end else sc <= sc + 32'd1;
  end
  assign nib = bus.y_to_led[{idx, 2'b00} +: 4];
`ifdef LED_ZERO_BLANK_EN
  assign blank = (idx == 3'd5 && bus.y_to_led[23:20] == 4'd0) || (idx == 3'd4 && bus.y_to_led[23:16] == 8'd0) ||
                 (idx == 3'd2 && bus.y_to_led[11:8] == 4'd0) || (idx == 3'd1 && bus.y_to_led[11:4] == 8'd0);
`else
  assign blank = 1'b0;
`endif
  assign bus.dig = ~(6'b1 << idx);
  assign bus.led_out = blank ? SEG_BLANK : glyph(nib);
endmodule

// File: tb/tb_uart_div_display.sv
// tb_uart_div_display: randomized and directed UART operand frames checked against an arithmetic reference model
module tb_uart_div_display;
  localparam int BITC = 16;
  localparam int SCAN = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0, cyc = 0, txcnt = 0, tx_base = 0, rx_cyc = 0, tx_cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] last_tx;
  logic [23:0] last_y;
  logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  uart_div_display_if bus();
  uart_div_display #(.CLK_FREQ(BITC * 9600), .BAUD(9600), .SCAN_CYCLES(SCAN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.rx_ready) begin
      rxq.push_back(bus.rx_data);
      rx_cyc = cyc;
    end
    if (bus.tx_ready) begin
      txcnt++;
      tx_cyc = cyc;
      last_tx = bus.tx_data;
      last_y = bus.y_to_led;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] bcd3(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction
  function automatic logic [6:0] exp_glyph(input logic [23:0] y, input int i);
    logic [3:0] n = y[i*4 +: 4];
    logic [11:0] f = y[(i/3)*12 +: 12];
    bit bl = 1'b0;
`ifdef LED_ZERO_BLANK_EN
    bl = (i % 3 == 2) ? f[11:8] == 4'd0 : (i % 3 == 1) ? f[11:4] == 8'd0 : 1'b0;
`else
    bl = f == 12'hFFF;
`endif
    return bl ? 7'h7F : n < 10 ? glyph_tab[n] : n == 4'hE ? 7'h06 : 7'h7F;
  endfunction
  task automatic send_byte(input logic [7:0] v, input logic stop = 1'b1);
    logic [9:0] fr = {stop, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = fr[i];
      repeat (BITC) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input int nb);
    logic [23:0] ey;
    logic [7:0] et;
    for (int i = 0; i < 200 && txcnt == tx_base; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    ey = b == 0 ? 24'hEEEEEE : {bcd3(a / b), bcd3(a % b)};
    et = b == 0 ? 8'hFF : a / b;
    check("rx_count", rxq.size(), nb);
    check("rx_last", rxq.size() > 0 ? rxq[$] : 8'hxx, b);
    check("tx_pulses", txcnt, tx_base + 1);
    check("tx_data", last_tx, et);
    check("y_at_pulse", last_y, ey);
    check("y_held", bus.y_to_led, ey);
    check("latency", (tx_cyc - rx_cyc <= 20) && (tx_cyc > rx_cyc), 1);
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    rxq.delete();
    tx_base = txcnt;
    send_byte(8'h73);
    send_byte(a);
    send_byte(8'h73);
    send_byte(b);
    finish_op(a, b, 4);
  endtask
  task automatic scan_check(input logic [23:0] y);
    logic [5:0] prev = bus.dig;
    logic [5:0] e;
    bit found = 1'b0;
    for (int i = 0; i < SCAN * 8 && !found; i++) begin
      @(negedge clk);
      found = prev != 6'b111110 && bus.dig == 6'b111110;
      prev = bus.dig;
    end
    check("scan_sync", found, 1);
    repeat (SCAN / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      e = ~(6'd1 << (k % 6));
      check("dig", bus.dig, e);
      check("led", bus.led_out, exp_glyph(y, k % 6));
      repeat (SCAN) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_scan_dig", bus.dig, 6'b111110);
    check("rst_scan_led", bus.led_out, 7'b1000000);
    check("rst_scan_y", bus.y_to_led, 0);
    rst = 1'b0;
  endtask
  initial begin
    logic [7:0] ra, rb;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_y", bus.y_to_led, 0);
    check("rst_dig", bus.dig, 6'b111110);
    check("rst_led", bus.led_out, 7'b1000000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_op(8'h03, 8'h01);
    check("led_digit3", exp_glyph(bus.y_to_led, 3), 7'b0110000);
    scan_check(bus.y_to_led);
    run_op(8'hFF, 8'h07);
    run_op(8'h05, 8'h00);
    rxq.delete();
    send_byte(8'h55);
    check("stray_rx", rxq.size(), 1);
    run_op(8'h08, 8'h02);
    check("stray_y", bus.y_to_led, 24'h004000);
    rxq.delete();
    tx_base = txcnt;
    send_byte(8'h73);
    send_byte(8'h09, 1'b0);
    check("badstop_norx", rxq.size(), 1);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_norx", rxq.size(), 1);
    send_byte(8'h06);
    send_byte(8'h73);
    send_byte(8'h02);
    finish_op(8'h06, 8'h02, 4);
    rxq.delete();
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midframe_norx", rxq.size(), 0);
    check("midframe_y", bus.y_to_led, 0);
    check("midframe_tx", bus.tx_data, 0);
    run_op(8'h09, 8'h04);
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = $urandom_range(0, 5) == 0 ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb);
    end
    scan_check(bus.y_to_led);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
